// File: rtl/slice_serial_adder.sv
// slice_serial_adder: WIDTH-bit add/subtract built from one SLICE-bit ripple
// slice that is reused once per clock, LSB slice first. The carry between
// slices is kept in a register. Results appear on s/cout/ovf/zero only
// when an operation completes, with a start/busy/done handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one slice processed per clock, carry kept in carry register
// DONE  | result valid for one cycle; start here begins a new RUN
module slice_serial_adder #(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N     = WIDTH / SLICE;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;

  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             ripple;
  logic             carry_into_msb;
  logic [WIDTH-1:0] acc_full;

  // One 283-style slice: bit-level ripple so the carry into the top bit of
  // the slice is visible for the overflow flag on the last slice.
  always_comb begin
    slice_a        = op_a[idx*SLICE +: SLICE];
    slice_b        = op_b[idx*SLICE +: SLICE];
    slice_sum      = '0;
    ripple         = carry;
    carry_into_msb = carry;
    for (int i = 0; i < SLICE; i++) begin
      if (i == SLICE - 1) carry_into_msb = ripple;
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ ripple;
      ripple       = (slice_a[i] & slice_b[i]) | (ripple & (slice_a[i] ^ slice_b[i]));
    end
    acc_full                       = acc;
    acc_full[idx*SLICE +: SLICE]   = slice_sum;
  end

  // Sequencer: accept, step slices, publish result; outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      op_a  <= '0;
      op_b  <= '0;
      acc   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= cin;
            idx   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          acc   <= acc_full;
          carry <= ripple;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            s     <= acc_full;
            cout  <= ripple;
            ovf   <= carry_into_msb ^ ripple;
            zero  <= (acc_full == '0);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slice_serial_adder.sv
// Directed bench for slice_serial_adder at WIDTH 4, 8 and 16 (SLICE 4).
module tb_slice_serial_adder;

  logic clk;
  logic reset;

  logic        start4, cin4, sub4, busy4, done4, cout4, ovf4, zero4;
  logic [3:0]  a4, b4, s4;
  logic        start8, cin8, sub8, busy8, done8, cout8, ovf8, zero8;
  logic [7:0]  a8, b8, s8;
  logic        start16, cin16, sub16, busy16, done16, cout16, ovf16, zero16;
  logic [15:0] a16, b16, s16;

  int tests;
  int fails;

  slice_serial_adder #(.WIDTH(4), .SLICE(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4), .zero(zero4)
  );

  slice_serial_adder #(.WIDTH(8), .SLICE(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
  );

  slice_serial_adder #(.WIDTH(16), .SLICE(4)) u_dut16 (
    .clk(clk), .reset(reset), .start(start16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Starts an 8-bit operation at the current negedge and waits (bounded) for
  // done. done_cyc counts cycles after the accepting edge (-1 on timeout).
  task automatic op8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                     input logic tsub, output int done_cyc, output int busy_cyc,
                     output logic [7:0] s_first);
    a8 = ta; b8 = tb_v; cin8 = tcin; sub8 = tsub; start8 = 1'b1;
    @(negedge clk);
    start8   = 1'b0;
    done_cyc = -1;
    busy_cyc = 0;
    s_first  = s8;
    for (int k = 1; k <= 20; k++) begin
      if (done8 === 1'b1) begin
        done_cyc = k;
        break;
      end
      if (busy8 === 1'b1) busy_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if (s8 !== 8'h00)  begin fails++; $display("FAIL reset_s: got %h want 00", s8); end
    tests++; if (cout8 !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout8); end
    tests++; if (ovf8 !== 1'b0)  begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
    tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b want 0", zero8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy8); end
    tests++; if (done16 !== 1'b0) begin fails++; $display("FAIL reset_done16: got %b want 0", done16); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_exhaustive4;
    logic [4:0] exp_full;
    int         sv;
    logic       exp_ovf;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          exp_full = 5'(ia + ib + ic);
          sv       = ((ia > 7) ? ia - 16 : ia) + ((ib > 7) ? ib - 16 : ib) + ic;
          exp_ovf  = (sv > 7) || (sv < -8);
          a4 = 4'(ia); b4 = 4'(ib); cin4 = 1'(ic); sub4 = 1'b0; start4 = 1'b1;
          @(negedge clk);
          start4 = 1'b0;
          tests++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin fails++;
            $display("FAIL ex4_run a=%0d b=%0d c=%0d: busy=%b done=%b want busy=1 done=0", ia, ib, ic, busy4, done4); end
          @(negedge clk);
          tests++; if (done4 !== 1'b1 || busy4 !== 1'b0) begin fails++;
            $display("FAIL ex4_done a=%0d b=%0d c=%0d: done=%b busy=%b want done=1 busy=0", ia, ib, ic, done4, busy4); end
          tests++; if (s4 !== exp_full[3:0]) begin fails++;
            $display("FAIL ex4_s a=%0d b=%0d c=%0d: got %h want %h", ia, ib, ic, s4, exp_full[3:0]); end
          tests++; if (cout4 !== exp_full[4]) begin fails++;
            $display("FAIL ex4_cout a=%0d b=%0d c=%0d: got %b want %b", ia, ib, ic, cout4, exp_full[4]); end
          tests++; if (ovf4 !== exp_ovf) begin fails++;
            $display("FAIL ex4_ovf a=%0d b=%0d c=%0d: got %b want %b", ia, ib, ic, ovf4, exp_ovf); end
          tests++; if (zero4 !== (exp_full[3:0] == 4'h0)) begin fails++;
            $display("FAIL ex4_zero a=%0d b=%0d c=%0d: got %b", ia, ib, ic, zero4); end
        end
      end
    end
    @(negedge clk);
    tests++; if (done4 !== 1'b0) begin fails++; $display("FAIL ex4_done_drop: got %b want 0", done4); end
  endtask

  task automatic test_add8;
    int dc, bc;
    logic [7:0] sf;
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, dc, bc, sf);
    tests++; if (dc != 3)      begin fails++; $display("FAIL add8_done_cycle: got %0d want 3", dc); end
    tests++; if (bc != 2)      begin fails++; $display("FAIL add8_busy_cycles: got %0d want 2", bc); end
    tests++; if (s8 !== 8'h96) begin fails++; $display("FAIL add8_s: got %h want 96", s8); end
    tests++; if (cout8 !== 1'b0) begin fails++; $display("FAIL add8_cout: got %b want 0", cout8); end
    tests++; if (ovf8 !== 1'b1)  begin fails++; $display("FAIL add8_ovf: got %b want 1", ovf8); end
    tests++; if (zero8 !== 1'b0) begin fails++; $display("FAIL add8_zero: got %b want 0", zero8); end
    @(negedge clk);
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL add8_done_pulse: got %b want 0", done8); end
    @(negedge clk);
    tests++; if (s8 !== 8'h96) begin fails++; $display("FAIL add8_idle_hold: got %h want 96", s8); end
  endtask

  task automatic test_wrap8;
    int dc, bc;
    logic [7:0] sf;
    op8(8'hFF, 8'h01, 1'b0, 1'b0, dc, bc, sf);
    tests++; if (sf !== 8'h96)  begin fails++; $display("FAIL wrap8_hold_in_run: got %h want 96", sf); end
    tests++; if (dc != 3)       begin fails++; $display("FAIL wrap8_done_cycle: got %0d want 3", dc); end
    tests++; if (s8 !== 8'h00)  begin fails++; $display("FAIL wrap8_s: got %h want 00", s8); end
    tests++; if (cout8 !== 1'b1) begin fails++; $display("FAIL wrap8_cout: got %b want 1", cout8); end
    tests++; if (ovf8 !== 1'b0)  begin fails++; $display("FAIL wrap8_ovf: got %b want 0", ovf8); end
    tests++; if (zero8 !== 1'b1) begin fails++; $display("FAIL wrap8_zero: got %b want 1", zero8); end
    @(negedge clk);
  endtask

  task automatic test_sub8;
    int dc, bc;
    logic [7:0] sf;
    op8(8'h10, 8'h01, 1'b1, 1'b1, dc, bc, sf);
    tests++; if (s8 !== 8'h0F)  begin fails++; $display("FAIL sub8a_s: got %h want 0f", s8); end
    tests++; if (cout8 !== 1'b1) begin fails++; $display("FAIL sub8a_cout: got %b want 1", cout8); end
    tests++; if (ovf8 !== 1'b0)  begin fails++; $display("FAIL sub8a_ovf: got %b want 0", ovf8); end
    // back-to-back from the DONE cycle
    op8(8'h80, 8'h01, 1'b1, 1'b1, dc, bc, sf);
    tests++; if (sf !== 8'h0F)  begin fails++; $display("FAIL sub8b_hold_in_run: got %h want 0f", sf); end
    tests++; if (dc != 3)       begin fails++; $display("FAIL sub8b_done_cycle: got %0d want 3", dc); end
    tests++; if (s8 !== 8'h7F)  begin fails++; $display("FAIL sub8b_s: got %h want 7f", s8); end
    tests++; if (ovf8 !== 1'b1)  begin fails++; $display("FAIL sub8b_ovf: got %b want 1", ovf8); end
    tests++; if (cout8 !== 1'b1) begin fails++; $display("FAIL sub8b_cout: got %b want 1", cout8); end
    @(negedge clk);
  endtask

  task automatic test_handshake16;
    int cnt;
    a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; sub16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cnt = 1;
    tests++; if (busy16 !== 1'b1) begin fails++; $display("FAIL hs16_busy: got %b want 1", busy16); end
    @(negedge clk);
    cnt = 2;
    a16 = 16'h0F0F; b16 = 16'h0101; cin16 = 1'b0; sub16 = 1'b1; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cnt = 3;
    for (int k = 0; k < 20; k++) begin
      if (done16 === 1'b1) break;
      @(negedge clk);
      cnt++;
    end
    tests++; if (cnt != 5)        begin fails++; $display("FAIL hs16_done_cycle: got %0d want 5", cnt); end
    tests++; if (s16 !== 16'h0000) begin fails++; $display("FAIL hs16_s: got %h want 0000", s16); end
    tests++; if (cout16 !== 1'b1)  begin fails++; $display("FAIL hs16_cout: got %b want 1", cout16); end
    tests++; if (ovf16 !== 1'b0)   begin fails++; $display("FAIL hs16_ovf: got %b want 0", ovf16); end
    tests++; if (zero16 !== 1'b1)  begin fails++; $display("FAIL hs16_zero: got %b want 1", zero16); end
    a16 = 16'h1234; b16 = 16'h1111; cin16 = 1'b0; sub16 = 1'b0; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cnt = 1;
    tests++; if (busy16 !== 1'b1 || done16 !== 1'b0) begin fails++;
      $display("FAIL hs16_b2b: busy=%b done=%b want busy=1 done=0", busy16, done16); end
    for (int k = 0; k < 20; k++) begin
      if (done16 === 1'b1) break;
      @(negedge clk);
      cnt++;
    end
    tests++; if (cnt != 5)        begin fails++; $display("FAIL hs16_b2b_done_cycle: got %0d want 5", cnt); end
    tests++; if (s16 !== 16'h2345) begin fails++; $display("FAIL hs16_b2b_s: got %h want 2345", s16); end
    tests++; if (cout16 !== 1'b0)  begin fails++; $display("FAIL hs16_b2b_cout: got %b want 0", cout16); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int dc, bc;
    logic [7:0] sf;
    bit seen_done;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if (s8 !== 8'h00)  begin fails++; $display("FAIL rst_mid_s: got %h want 00", s8); end
    tests++; if (cout8 !== 1'b0 || ovf8 !== 1'b0 || zero8 !== 1'b0) begin fails++;
      $display("FAIL rst_mid_flags: cout=%b ovf=%b zero=%b want 0 0 0", cout8, ovf8, zero8); end
    tests++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin fails++;
      $display("FAIL rst_mid_hs: busy=%b done=%b want 0 0", busy8, done8); end
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) seen_done = 1'b1;
    end
    tests++; if (seen_done) begin fails++; $display("FAIL rst_mid_no_done: got activity want none"); end
    op8(8'h11, 8'h22, 1'b0, 1'b0, dc, bc, sf);
    tests++; if (dc != 3)      begin fails++; $display("FAIL rst_after_done_cycle: got %0d want 3", dc); end
    tests++; if (s8 !== 8'h33) begin fails++; $display("FAIL rst_after_s: got %h want 33", s8); end
    @(negedge clk);
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b1;
    start4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0;
    start8 = 0; a8 = '0; b8 = '0; cin8 = 0; sub8 = 0;
    start16 = 0; a16 = '0; b16 = '0; cin16 = 0; sub16 = 0;
    test_reset;
    test_exhaustive4;
    test_add8;
    test_wrap8;
    test_sub8;
    test_handshake16;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slice_serial_adder.md
Name: slice_serial_adder

Overview:
- Parametrised multi-cycle adder/subtractor built from a SLICE-bit 74xx283-style adder slice.
- Processes one slice per clock, LSB slice first, with the ripple carry held in a register between cycles.
- Gives the emulator a WIDTH-bit ALU add path that can use 4-bit adder chips in time-multiplexed form.
- Adds subtract mode, status flags and a start/busy/done handshake.

Parameters:
- WIDTH, 8: operand and result width in bits; must be a non-zero multiple of SLICE.
- SLICE, 4: bits processed per clock (the adder slice width).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only when an operation can be accepted.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- cin  input  1  carry in; captured on the accepting edge.
- sub  input  1  1 = use ~b instead of b; captured on the accepting edge.
- busy  output  1  high while slices are being processed (RUN state).
- done  output  1  one-cycle pulse when a result is valid.
- s  output  WIDTH  result.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement overflow.
- zero  output  1  high when s == 0.

Behaviour:
- N = WIDTH/SLICE. States are IDLE, RUN and DONE.
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE, slice index = 0, carry register = 0.
  - busy = 0, done = 0, s = 0, cout = 0, ovf = 0, zero = 0.
  - Any partial operation is discarded.
- Accepting a request:
  - In IDLE or DONE, start = 1 at a rising edge latches a, b (or ~b if sub = 1) and cin into internal registers.
  - The same edge sets slice index = 0 and moves the state to RUN.
- start while in RUN is ignored; there is no queueing and the latched operands are unchanged.
- Each RUN edge computes {c, sum} = A[slice] + B'[slice] + carry.
  - The sum is written into an internal accumulator at the slice position; c goes into the carry register.
  - The slice index is incremented.
  - On the edge that processes slice N-1, the state moves to DONE.
- Output update on the edge entering DONE:
  - s = full accumulated sum.
  - cout = final carry.
  - ovf = carry into MSB XOR carry out of MSB, computed bit-accurately inside the last slice.
  - zero = (s == 0).
- Output holding: s, cout, ovf and zero hold their values through IDLE and the next RUN. They change only on completion or reset; intermediate slices never appear on s.
- Latency: accept at edge E0, slices at E1..EN; busy = 1 from after E0 until after EN; done = 1 for exactly the one cycle after EN.
- DONE always leaves after one cycle: to RUN if start = 1 (back-to-back operation, done then drops), otherwise to IDLE.
- Subtract semantics: result = a + ~b + cin. A plain A-B is done with cin = 1; a borrow chain uses cin = previous cout. The value of cout is not inverted.
- When N = 1, the block degenerates to a single-slice adder with latency 1 plus the done cycle.
- Arithmetic is unsigned modulo 2^WIDTH. ovf is valid for both add and subtract modes.

Test Plan:
- Exhaustive slice, WIDTH = SLICE = 4: all a, b in 0..15, cin in {0,1}, sub = 0.
  - Required: s = (a+b+cin)[3:0], cout = bit 4.
  - done pulses one cycle after each single RUN edge.
- WIDTH = 8: a = 0x5A, b = 0x3C, cin = 0.
  - Required: s = 0x96, cout = 0, ovf = 1, zero = 0.
  - busy high for 2 cycles, done high on the 3rd cycle after the accepting edge.
- WIDTH = 8: a = 0xFF, b = 0x01, cin = 0 → s = 0x00, cout = 1, ovf = 0, zero = 1.
- WIDTH = 8 subtract: a = 0x10, b = 0x01, sub = 1, cin = 1 → s = 0x0F, cout = 1, ovf = 0.
  - Then a = 0x80, b = 0x01, sub = 1, cin = 1 → s = 0x7F, ovf = 1.
- Handshake, WIDTH = 16: accept a = 0xFFFF, b = 0, cin = 1.
  - Pulse start with different operands during RUN: that start is ignored.
  - Required: s = 0x0000, cout = 1, done after 4 RUN cycles.
  - Hold start high in the DONE cycle: a new RUN begins with no IDLE cycle.
- Reset mid-RUN: assert reset after the 1st slice.
  - All outputs go to 0 immediately; no done pulse follows.
  - The next start gives a correct result.
